// File: rtl/ps2_pkg.sv
// Shared state encoding, frame payload, default timing and helpers for the PS/2 host transmitter.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_EDGE,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_state_e;

  // Bits presented on falling edges 1..10, LSB first: D0..D7, parity, stop.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  localparam int unsigned DEF_INHIBIT_CYCLES     = 3000;
  localparam int unsigned DEF_RTS_CYCLES         = 25;
  localparam int unsigned DEF_FIRST_EDGE_TIMEOUT = 375000;
  localparam int unsigned DEF_PACKET_TIMEOUT     = 50000;
  localparam int unsigned DEF_FILTER_LEN         = 8;

  localparam int unsigned FRAME_W = $bits(ps2_frame_t);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser and falling-edge detector for the PS/2 clock pad.
// Build option PS2_TX_GLITCH_FILTER_EN debounces the synced level before edge detection.
module ps2_line_sync
`ifdef PS2_TX_GLITCH_FILTER_EN
#(
  parameter int unsigned FILTER_LEN = 8
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out,
  output logic fall_c
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       level;

  // Idle bus is high, so the chain resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], line_in};
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

  logic [FCNT_W-1:0] fcnt_q;
  logic              filt_q;

  // Output moves only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (sync_q[1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
      filt_q <= sync_q[1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level;
  end

  assign line_out = level;
  assign fall_c   = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Build option PS2_TX_GLITCH_FILTER_EN adds a debounce filter on the synced PS/2 clock.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES     = DEF_INHIBIT_CYCLES,
  parameter int unsigned RTS_CYCLES         = DEF_RTS_CYCLES,
  parameter int unsigned FIRST_EDGE_TIMEOUT = DEF_FIRST_EDGE_TIMEOUT,
  parameter int unsigned PACKET_TIMEOUT     = DEF_PACKET_TIMEOUT
`ifdef PS2_TX_GLITCH_FILTER_EN
  , parameter int unsigned FILTER_LEN       = DEF_FILTER_LEN
`endif
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_In,
  input  logic [7:0] Tx_Data_In,
  input  logic       Tx_Valid_In,
  output logic       Tx_Ready_Out,
  output logic       Tx_Done_Out,
  output logic       Tx_Err_Out,
  output logic       Rx_Inhibit_Out,
  input  logic       PS2_Clk_In,
  input  logic       PS2_Data_In,
  output logic       PS2_Clk_Drive_Low_Out,
  output logic       PS2_Data_Drive_Low_Out
);

  localparam int unsigned MAX_CYCLES = max_u(max_u(INHIBIT_CYCLES, RTS_CYCLES),
                                             max_u(FIRST_EDGE_TIMEOUT, PACKET_TIMEOUT));
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] INHIBIT_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST      = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_LAST    = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PACKET_LAST   = CNT_W'(PACKET_TIMEOUT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(FRAME_W - 1);

  ps2_state_e       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [BIT_W-1:0] bit_q, bit_n;
  ps2_frame_t       frame_q, frame_n;
  logic             data_drv_n;

  logic             clk_sync;
  logic             clk_fall_c;
  logic [1:0]       data_sync_q;
  logic             data_sync;

  ps2_line_sync
`ifdef PS2_TX_GLITCH_FILTER_EN
  #(.FILTER_LEN(FILTER_LEN))
`endif
  u_clk_sync (
    .clk      (Master_Clock_In),
    .rst      (Reset_In),
    .line_in  (PS2_Clk_In),
    .line_out (clk_sync),
    .fall_c   (clk_fall_c)
  );

  // Data only needs metastability protection; it is sampled on clock edges.
  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) data_sync_q <= 2'b11;
    else          data_sync_q <= {data_sync_q[0], PS2_Data_In};
  end

  assign data_sync = data_sync_q[1];
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      frame_q <= frame_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_inc;
    bit_n      = bit_q;
    frame_n    = frame_q;
    data_drv_n = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (Tx_Valid_In) begin
          frame_n.stop   = 1'b1;
          frame_n.parity = odd_parity(Tx_Data_In);
          frame_n.data   = Tx_Data_In;
          state_n        = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_n   = '0;
          state_n = RTS;
        end
      end
      RTS: begin
        if (cnt_q == RTS_LAST) begin
          cnt_n   = '0;
          state_n = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        if (clk_fall_c) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = SHIFT;
        end else if (cnt_q == FIRST_LAST) begin
          state_n = ERR;
        end
      end
      SHIFT: begin
        if (cnt_q == PACKET_LAST) begin
          state_n = ERR;
        end else if (clk_fall_c) begin
          // The edge after the stop bit is the device's ACK clock.
          if (bit_q == LAST_BIT) state_n = ACK;
          else                   bit_n   = bit_q + BIT_W'(1);
        end
      end
      ACK: begin
        if (cnt_q == PACKET_LAST) state_n = ERR;
        else if (!data_sync)      state_n = WAIT_IDLE;
        else                      state_n = ERR;
      end
      WAIT_IDLE: begin
        if (cnt_q == PACKET_LAST)        state_n = ERR;
        else if (clk_sync && data_sync)  state_n = DONE;
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Drives are decoded from the next state so they change the cycle after an edge.
    case (state_n)
      RTS, WAIT_EDGE: data_drv_n = 1'b1;
      SHIFT:          data_drv_n = ~frame_q[bit_n];
      default:        data_drv_n = 1'b0;
    endcase
  end

  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      Tx_Ready_Out           <= 1'b1;
      Tx_Done_Out            <= 1'b0;
      Tx_Err_Out             <= 1'b0;
      Rx_Inhibit_Out         <= 1'b0;
      PS2_Clk_Drive_Low_Out  <= 1'b0;
      PS2_Data_Drive_Low_Out <= 1'b0;
    end else begin
      Tx_Ready_Out           <= (state_n == IDLE);
      Tx_Done_Out            <= (state_n == DONE);
      Tx_Err_Out             <= (state_n == ERR);
      Rx_Inhibit_Out         <= (state_n != IDLE);
      PS2_Clk_Drive_Low_Out  <= (state_n == INHIBIT) || (state_n == RTS);
      PS2_Data_Drive_Low_Out <= data_drv_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised scoreboard bench for ps2_host_tx with a behavioural keyboard model on the open-drain bus.
module tb_ps2_host_tx;

  localparam int unsigned INH       = 100;
  localparam int unsigned RTS_C     = 10;
  localparam int unsigned FET       = 3000;
  localparam int unsigned PKT       = 2000;
  localparam int unsigned H         = 40;
  localparam int unsigned START_DLY = 50;
  localparam int unsigned NTX       = 16;

  typedef enum int {M_ACK, M_NACK, M_NOCLK, M_STALL} mode_e;

  typedef struct {
    logic [7:0] data;
    mode_e      mode;
  } exp_t;

  typedef struct {
    int          inh;
    int          rts;
    int unsigned rel;
    int unsigned fall1;
    logic [10:0] frame;
    bit          has_frame;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       Tx_Ready_Out, Tx_Done_Out, Tx_Err_Out, Rx_Inhibit_Out;
  logic       PS2_Clk_Drive_Low_Out, PS2_Data_Drive_Low_Out;
  logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
  logic       bus_clk, bus_data;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  mode_e       dev_mode = M_ACK;
  exp_t        exp_q[$];
  obs_t        obs_q[$];

  assign bus_clk  = ~PS2_Clk_Drive_Low_Out & dev_clk & ~glitch;
  assign bus_data = ~PS2_Data_Drive_Low_Out & dev_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(
    .INHIBIT_CYCLES     (INH),
    .RTS_CYCLES         (RTS_C),
    .FIRST_EDGE_TIMEOUT (FET),
    .PACKET_TIMEOUT     (PKT)
  ) dut (
    .Master_Clock_In        (clk),
    .Reset_In               (rst),
    .Tx_Data_In             (tx_data),
    .Tx_Valid_In            (tx_valid),
    .Tx_Ready_Out           (Tx_Ready_Out),
    .Tx_Done_Out            (Tx_Done_Out),
    .Tx_Err_Out             (Tx_Err_Out),
    .Rx_Inhibit_Out         (Rx_Inhibit_Out),
    .PS2_Clk_In             (bus_clk),
    .PS2_Data_In            (bus_data),
    .PS2_Clk_Drive_Low_Out  (PS2_Clk_Drive_Low_Out),
    .PS2_Data_Drive_Low_Out (PS2_Data_Drive_Low_Out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Full 11-bit frame as the keyboard sees it: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Keyboard model: measures inhibit/RTS, then clocks the frame in and optionally ACKs.
  initial begin : device
    obs_t  o;
    mode_e m;
    forever begin
      step();
      if (!PS2_Clk_Drive_Low_Out) continue;
      o = '{default: 0};
      while (PS2_Clk_Drive_Low_Out && !PS2_Data_Drive_Low_Out) begin o.inh++; step(); end
      while (PS2_Clk_Drive_Low_Out && PS2_Data_Drive_Low_Out) begin o.rts++; step(); end
      o.rel = cyc;
      m = dev_mode;
      if (m == M_NOCLK) begin
        obs_q.push_back(o);
        continue;
      end
      repeat (START_DLY) step();
      o.frame[0] = bus_data;
      o.fall1    = cyc;
      for (int i = 1; i <= 10; i++) begin
        if (m == M_STALL && i > 5) break;
        dev_clk = 1'b0;
        repeat (H) step();
        dev_clk = 1'b1;
        repeat (H / 2) step();
        o.frame[i] = bus_data;
`ifdef PS2_TX_GLITCH_FILTER_EN
        if (i == 4) begin
          repeat (5) step();
          glitch = 1'b1;
          repeat (3) step();
          glitch = 1'b0;
          repeat (H / 2 - 8) step();
        end else begin
          repeat (H / 2) step();
        end
`else
        repeat (H / 2) step();
`endif
      end
      if (m == M_STALL) begin
        obs_q.push_back(o);
        continue;
      end
      o.has_frame = 1'b1;
      obs_q.push_back(o);
      if (m == M_ACK) begin
        dev_data = 1'b0;
        repeat (4) step();
      end
      dev_clk = 1'b0;
      repeat (H) step();
      dev_clk = 1'b1;
      repeat (4) step();
      dev_data = 1'b1;
    end
  end

  // Monitor: every Done/Err pulse retires one expected transaction.
  initial begin : monitor
    exp_t e;
    obs_t o;
    int   lat;
    forever begin
      step();
      if (rst) continue;
      if (Tx_Done_Out || Tx_Err_Out) begin
        chk("done_err_exclusive", int'(Tx_Done_Out & Tx_Err_Out), 0);
        chk("ready_low_at_end", int'(Tx_Ready_Out), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_packet", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("outcome_done", int'(Tx_Done_Out), int'(e.mode == M_ACK));
          if (obs_q.size() == 0) begin
            chk("device_obs_missing", 1, 0);
          end else begin
            o = obs_q.pop_front();
            chk("inhibit_len", o.inh, int'(INH));
            chk("rts_len", o.rts, int'(RTS_C));
            if (e.mode == M_NOCLK) begin
              chk("first_edge_timeout_latency", int'(cyc - o.rel), int'(FET));
            end else if (e.mode == M_STALL) begin
              lat = int'(cyc - o.fall1);
              chk("packet_timeout_window", int'(lat >= int'(PKT) + 3 && lat <= int'(PKT) + 16), 1);
            end else begin
              chk("frame_bits", int'(o.frame), int'(model_frame(e.data)));
              chk("frame_bit_count", int'(o.has_frame), 1);
            end
          end
        end
        step();
        chk("ready_after_end", int'(Tx_Ready_Out), 1);
        chk("lines_released", int'({PS2_Clk_Drive_Low_Out, PS2_Data_Drive_Low_Out}), 0);
        chk("pulse_single", int'({Tx_Done_Out, Tx_Err_Out}), 0);
      end
    end
  end

  task automatic send(input logic [7:0] b, input mode_e m, input bit junk);
    int n;
    int ready_hi;
    dev_mode = m;
    n = 0;
    while (!Tx_Ready_Out && n < 5000) begin step(); n++; end
    if (!Tx_Ready_Out) begin
      chk("ready_wait_timeout", 0, 1);
      return;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back('{data: b, mode: m});
    step();
    chk("ready_drops", int'(Tx_Ready_Out), 0);
    chk("rx_inhibit_set", int'(Rx_Inhibit_Out), 1);
    if (junk) tx_data = 8'h55;
    else      tx_valid = 1'b0;
    n = 0;
    ready_hi = 0;
    while (!(Tx_Done_Out || Tx_Err_Out) && n < 20000) begin
      if (Tx_Ready_Out) ready_hi++;
      step();
      n++;
    end
    tx_valid = 1'b0;
    if (junk) chk("ready_low_with_valid_held", ready_hi, 0);
    if (!(Tx_Done_Out || Tx_Err_Out)) begin
      chk("txn_timeout", 0, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
    end
    repeat (2 * H + 20) step();
  endtask

  initial begin : stim
    logic [7:0] b;
    mode_e      m;
    bit         junk;
    int         r;
    int         n;

    repeat (5) step();
    chk("rst_ready", int'(Tx_Ready_Out), 1);
    chk("rst_done", int'(Tx_Done_Out), 0);
    chk("rst_err", int'(Tx_Err_Out), 0);
    chk("rst_inhibit", int'(Rx_Inhibit_Out), 0);
    chk("rst_drives", int'({PS2_Clk_Drive_Low_Out, PS2_Data_Drive_Low_Out}), 0);
    #2 rst = 1'b0;
    step();

    for (int t = 0; t < int'(NTX); t++) begin
      junk = 1'b0;
      case (t)
        0: begin b = 8'hED; m = M_ACK;   end
        1: begin b = 8'h07; m = M_NACK;  end
        2: begin b = 8'hFF; m = M_NOCLK; end
        3: begin b = 8'hED; m = M_ACK; junk = 1'b1; end
        4: begin b = 8'hF0; m = M_STALL; end
        default: begin
          b    = 8'($urandom);
          r    = int'($urandom_range(0, 5));
          m    = (r <= 2) ? M_ACK : (r == 3) ? M_NACK : (r == 4) ? M_NOCLK : M_STALL;
          junk = 1'($urandom_range(0, 1));
        end
      endcase
      send(b, m, junk);
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    obs_q.delete();

    // Asynchronous reset while both lines are pulled low (RTS).
    dev_mode = M_NOCLK;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n = 0;
    while (!PS2_Data_Drive_Low_Out && n < 1000) begin step(); n++; end
    chk("rts_data_low", int'(PS2_Data_Drive_Low_Out), 1);
    chk("rts_clk_low", int'(PS2_Clk_Drive_Low_Out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clk_release", int'(PS2_Clk_Drive_Low_Out), 0);
    chk("async_rst_data_release", int'(PS2_Data_Drive_Low_Out), 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", int'(Tx_Ready_Out), 1);
    chk("post_rst_pulses", int'({Tx_Done_Out, Tx_Err_Out}), 0);
    chk("post_rst_inhibit", int'(Rx_Inhibit_Out), 0);
    repeat (20) step();
    obs_q.delete();

    // Asynchronous reset in the middle of SHIFT while D0=0 is being driven.
    dev_mode = M_ACK;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n = 0;
    while (!PS2_Clk_Drive_Low_Out && n < 1000) begin step(); n++; end
    n = 0;
    while (PS2_Clk_Drive_Low_Out && n < 1000) begin step(); n++; end
    repeat (START_DLY + H) step();
    chk("shift_d0_drive", int'(PS2_Data_Drive_Low_Out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_shift_clk", int'(PS2_Clk_Drive_Low_Out), 0);
    chk("async_rst_shift_data", int'(PS2_Data_Drive_Low_Out), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_shift_rst_ready", int'(Tx_Ready_Out), 1);
    chk("post_shift_rst_pulses", int'({Tx_Done_Out, Tx_Err_Out}), 0);
    repeat (1200) step();
    chk("idle_after_abort", int'(Tx_Ready_Out), 1);
    obs_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
